// File: rtl/tick_monitor.sv
// Purpose: receive-side health monitor for periodic single-cycle enable strobes (lock / short / missing).
// Latency: every output is registered and reflects a TICK or a missing-tick deadline one CLOCK later.
// Backpressure: none; the block observes TICK only and can never stall its source.
//
// Ports:
//   CLOCK, RESET_N   rising-edge clock, asynchronous active-low reset
//   EN               monitor enable; low forces IDLE (status and PERIOD_OUT are held)
//   TICK             strobe under test; each high cycle is one tick
//   CLEAR            one-cycle pulse clearing FAULT, ERR_CODE and ERR_CNT
//   LOCKED           high while the tick cadence is verified
//   FAULT            sticky error flag
//   ERR_CODE         first error since the last clear: 00 none, 01 short, 10 missing
//   ERR_CNT          saturating error count
//   PERIOD_OUT       last measured period in cycles
//   PERIOD_VALID     one-cycle pulse when PERIOD_OUT updates
module tick_monitor #(
    parameter int PERIOD     = 75001,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 4,
    localparam int W         = $clog2(PERIOD + TOL + 2)
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         EN,
    input  logic         TICK,
    input  logic         CLEAR,
    output logic         LOCKED,
    output logic         FAULT,
    output logic [1:0]   ERR_CODE,
    output logic [7:0]   ERR_CNT,
    output logic [W-1:0] PERIOD_OUT,
    output logic         PERIOD_VALID
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]  LO_LIM   = W'(PERIOD - TOL);
    localparam logic [W-1:0]  HI_LIM   = W'(PERIOD + TOL);
    localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_SHORT = 2'b01;
    localparam logic [1:0] CODE_MISS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  cnt;
    logic [GW-1:0] good;

    logic          measuring;
    logic          err_short;
    logic          err_miss;
    logic [W-1:0]  cnt_inc;
    logic [GW-1:0] good_inc;

    // ARM counts toward the missing deadline too, but only TRACK/LOCKED
    // have a reference tick and can therefore produce a period.
    always_comb begin
        measuring = 1'b0;
        err_short = 1'b0;
        err_miss  = 1'b0;
        if (EN && state != ST_IDLE) begin
            measuring = 1'b1;
            if (TICK) begin
                err_short = (state != ST_ARM) && (cnt < LO_LIM);
            end else begin
                err_miss  = (cnt == HI_LIM);
            end
        end
    end

    // The saturation is never reached in practice: the missing deadline fires first.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + W'(1);
    assign good_inc = (good == GOOD_MAX) ? good : good + GW'(1);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            good         <= '0;
            LOCKED       <= 1'b0;
            PERIOD_OUT   <= '0;
            PERIOD_VALID <= 1'b0;
        end else begin
            PERIOD_VALID <= 1'b0;
            if (!EN) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                good   <= '0;
                LOCKED <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARM;
                        cnt   <= '0;
                    end
                    ST_ARM: begin
                        if (TICK) begin
                            // First tick is only a reference; no period yet.
                            cnt   <= W'(1);
                            state <= ST_TRACK;
                        end else if (err_miss) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_TRACK, ST_LOCKED: begin
                        if (TICK) begin
                            PERIOD_OUT   <= cnt;
                            PERIOD_VALID <= 1'b1;
                            cnt          <= W'(1);
                            if (err_short) begin
                                good   <= '0;
                                LOCKED <= 1'b0;
                                state  <= ST_TRACK;
                            end else begin
                                good <= good_inc;
                                if (good_inc == GOOD_MAX) begin
                                    LOCKED <= 1'b1;
                                    state  <= ST_LOCKED;
                                end
                            end
                        end else if (err_miss) begin
                            cnt    <= '0;
                            good   <= '0;
                            LOCKED <= 1'b0;
                            state  <= ST_ARM;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        good   <= '0;
                        LOCKED <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error status. CLEAR is applied first so that an error landing in the
    // same cycle survives the clear as the first recorded error.
    logic       err_any;
    logic [1:0] code_base;
    logic [7:0] errcnt_base;

    assign err_any     = measuring && (err_short || err_miss);
    assign code_base   = CLEAR ? CODE_NONE : ERR_CODE;
    assign errcnt_base = CLEAR ? 8'd0 : ERR_CNT;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            FAULT    <= 1'b0;
            ERR_CODE <= CODE_NONE;
            ERR_CNT  <= 8'd0;
        end else begin
            if (err_any) begin
                FAULT    <= 1'b1;
                ERR_CODE <= (code_base != CODE_NONE) ? code_base
                          : (err_short ? CODE_SHORT : CODE_MISS);
                ERR_CNT  <= (errcnt_base == 8'hFF) ? errcnt_base : errcnt_base + 8'd1;
            end else begin
                FAULT    <= CLEAR ? 1'b0 : FAULT;
                ERR_CODE <= code_base;
                ERR_CNT  <= errcnt_base;
            end
        end
    end

endmodule

// File: tb/tb_tick_monitor.sv
module tb_tick_monitor;

    localparam int P  = 10;
    localparam int T  = 2;
    localparam int LC = 3;
    localparam int TW = $clog2(P + T + 2);

    logic          CLOCK;
    logic          RESET_N;
    logic          EN;
    logic          TICK;
    logic          CLEAR;
    logic          LOCKED;
    logic          FAULT;
    logic [1:0]    ERR_CODE;
    logic [7:0]    ERR_CNT;
    logic [TW-1:0] PERIOD_OUT;
    logic          PERIOD_VALID;

    int n_total = 0;
    int n_pass  = 0;

    tick_monitor #(.PERIOD(P), .TOL(T), .LOCK_COUNT(LC)) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .EN           (EN),
        .TICK         (TICK),
        .CLEAR        (CLEAR),
        .LOCKED       (LOCKED),
        .FAULT        (FAULT),
        .ERR_CODE     (ERR_CODE),
        .ERR_CNT      (ERR_CNT),
        .PERIOD_OUT   (PERIOD_OUT),
        .PERIOD_VALID (PERIOD_VALID)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: drive inputs, take the edge, settle just after it.
    task automatic cyc(input logic t, input logic c);
        TICK  = t;
        CLEAR = c;
        @(posedge CLOCK);
        #1;
        TICK  = 1'b0;
        CLEAR = 1'b0;
    endtask

    // Tick p cycles after the previous tick.
    task automatic period(input int p);
        repeat (p - 1) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(LOCKED), 0);
        chk({tag, "_fault"},  32'(FAULT), 0);
        chk({tag, "_code"},   32'(ERR_CODE), 0);
        chk({tag, "_errcnt"}, 32'(ERR_CNT), 0);
        chk({tag, "_pout"},   32'(PERIOD_OUT), 0);
        chk({tag, "_pvld"},   32'(PERIOD_VALID), 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        EN      = 1'b0;
        TICK    = 1'b0;
        CLEAR   = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        chk_zero("reset");

        // Release reset; IDLE -> ARM, then the reference tick gives no period.
        RESET_N = 1'b1;
        EN      = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("arm_ref_pvld", 32'(PERIOD_VALID), 0);

        // Lock on three good 10-cycle periods.
        period(10);
        chk("lock1_pvld", 32'(PERIOD_VALID), 1);
        chk("lock1_pout", 32'(PERIOD_OUT), 10);
        chk("lock1_locked", 32'(LOCKED), 0);
        period(10);
        chk("lock2_pvld", 32'(PERIOD_VALID), 1);
        chk("lock2_locked", 32'(LOCKED), 0);
        period(10);
        chk("lock3_pvld", 32'(PERIOD_VALID), 1);
        chk("lock3_pout", 32'(PERIOD_OUT), 10);
        chk("lock3_locked", 32'(LOCKED), 1);
        chk("lock3_fault", 32'(FAULT), 0);
        cyc(1'b0, 1'b0);
        chk("pvld_one_cycle", 32'(PERIOD_VALID), 0);
        chk("still_locked", 32'(LOCKED), 1);
        period(9);

        // Short period while locked.
        period(7);
        chk("short_pout", 32'(PERIOD_OUT), 7);
        chk("short_locked", 32'(LOCKED), 0);
        chk("short_fault", 32'(FAULT), 1);
        chk("short_code", 32'(ERR_CODE), 1);
        chk("short_errcnt", 32'(ERR_CNT), 1);
        period(10);
        period(10);
        chk("relock2_locked", 32'(LOCKED), 0);
        period(10);
        chk("relock3_locked", 32'(LOCKED), 1);

        // Clear, then tolerance boundaries.
        cyc(1'b0, 1'b1);
        chk("clear_fault", 32'(FAULT), 0);
        chk("clear_code", 32'(ERR_CODE), 0);
        chk("clear_errcnt", 32'(ERR_CNT), 0);
        period(9);
        chk("clr_period_locked", 32'(LOCKED), 1);
        period(8);
        chk("p8_pout", 32'(PERIOD_OUT), 8);
        chk("p8_fault", 32'(FAULT), 0);
        chk("p8_locked", 32'(LOCKED), 1);
        period(12);
        chk("p12_pout", 32'(PERIOD_OUT), 12);
        chk("p12_fault", 32'(FAULT), 0);
        chk("p12_locked", 32'(LOCKED), 1);
        period(7);
        chk("p7_code", 32'(ERR_CODE), 1);
        chk("p7_locked", 32'(LOCKED), 0);

        // Missing tick with ERR_CODE cleared beforehand.
        cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0);
        chk("pre_miss_fault", 32'(FAULT), 0);
        cyc(1'b0, 1'b0);
        chk("miss_fault", 32'(FAULT), 1);
        chk("miss_code", 32'(ERR_CODE), 2);
        chk("miss_errcnt", 32'(ERR_CNT), 1);
        chk("miss_locked", 32'(LOCKED), 0);
        cyc(1'b1, 1'b0);
        chk("miss_ref_pvld", 32'(PERIOD_VALID), 0);

        // Build ERR_CODE=01, ERR_CNT=5; a later missing must not overwrite the code.
        cyc(1'b0, 1'b1);
        period(6);
        chk("sh1_code", 32'(ERR_CODE), 1);
        chk("sh1_errcnt", 32'(ERR_CNT), 1);
        period(7);
        period(7);
        period(7);
        chk("sh4_errcnt", 32'(ERR_CNT), 4);
        repeat (12) cyc(1'b0, 1'b0);
        chk("miss_keep_code", 32'(ERR_CODE), 1);
        chk("miss_keep_errcnt", 32'(ERR_CNT), 5);

        // CLEAR coincident with a short error.
        cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("clr_err_fault", 32'(FAULT), 1);
        chk("clr_err_code", 32'(ERR_CODE), 1);
        chk("clr_err_errcnt", 32'(ERR_CNT), 1);

        // Saturation with back-to-back ticks.
        repeat (253) cyc(1'b1, 1'b0);
        chk("sat_254", 32'(ERR_CNT), 254);
        repeat (47) cyc(1'b1, 1'b0);
        chk("sat_255", 32'(ERR_CNT), 255);
        chk("sat_pout", 32'(PERIOD_OUT), 1);

        // Relock, then drop EN together with a would-be tick.
        period(10);
        period(10);
        period(10);
        chk("en_pre_locked", 32'(LOCKED), 1);
        repeat (9) cyc(1'b0, 1'b0);
        EN = 1'b0;
        cyc(1'b1, 1'b0);
        chk("en_off_locked", 32'(LOCKED), 0);
        chk("en_off_pvld", 32'(PERIOD_VALID), 0);
        chk("en_off_fault", 32'(FAULT), 1);
        chk("en_off_pout", 32'(PERIOD_OUT), 10);
        chk("en_off_errcnt", 32'(ERR_CNT), 255);

        // Asynchronous reset in the middle of a PERIOD_VALID cycle.
        EN = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        period(10);
        chk("pre_rst_pvld", 32'(PERIOD_VALID), 1);
        RESET_N = 1'b0;
        #1;
        chk_zero("async_rst");
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("post_rst_pvld", 32'(PERIOD_VALID), 0);
        chk("post_rst_locked", 32'(LOCKED), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Receive-side checker for periodic single-cycle enable strobes such as those produced by the team's clock-enable dividers. It measures the cycle distance between consecutive TICK pulses and declares lock after a run of in-tolerance periods. It flags short and missing ticks with sticky fault status and reports the last measured period. It sits beside any divided-enable consumer (UART baud, sampling, SOM update strobes) as a health monitor.

## Interface
- PERIOD, 75001: nominal tick period in CLOCK cycles. Constraint: PERIOD > TOL.
- TOL, 16: allowed deviation in cycles. A period is in range iff PERIOD-TOL <= p <= PERIOD+TOL.
- LOCK_COUNT, 4: consecutive in-range periods required to assert LOCKED. Constraint: >= 1.
- W (localparam): $clog2(PERIOD+TOL+2), the width of the counter and PERIOD_OUT.
- CLOCK in 1: sole clock. All logic is on the rising edge.
- RESET_N in 1: asynchronous, active-low reset.
- EN in 1: monitor enable. When low, the block is held in IDLE.
- TICK in 1: strobe under test. Each high cycle counts as one tick.
- CLEAR in 1: single-cycle pulse that clears FAULT, ERR_CODE and ERR_CNT.
- LOCKED out 1: high while tick cadence is verified.
- FAULT out 1: sticky error flag.
- ERR_CODE out 2: code of the first error since the last clear. 00 none, 01 short, 10 missing, 11 unused.
- ERR_CNT out 8: saturating error count. Holds at 255.
- PERIOD_OUT out W: last measured period in cycles.
- PERIOD_VALID out 1: one-cycle pulse when PERIOD_OUT updates.

## Operation
- State machine states: IDLE, ARM, TRACK, LOCKED. A good-period counter `good` runs 0..LOCK_COUNT.
- Cycle counter `cnt`:
  - Set to 1 on a tick cycle.
  - Otherwise increments each cycle in ARM/TRACK/LOCKED.
  - Cleared to 0 on entry to ARM or IDLE.
  - At a tick, the measured period p equals the current cnt.
- IDLE: entered whenever EN=0, regardless of state.
  - LOCKED<=0, cnt<=0, good<=0, TICK ignored.
  - FAULT, ERR_CODE, ERR_CNT and PERIOD_OUT hold their values.
  - Goes to ARM when EN=1.
- ARM: waits for the first tick, which serves as a reference.
  - On TICK: cnt<=1, go to TRACK.
  - No PERIOD_VALID is produced in ARM.
- TRACK/LOCKED, on TICK:
  - PERIOD_OUT<=cnt and PERIOD_VALID pulses.
  - In range: good<=min(good+1, LOCK_COUNT). When good reaches LOCK_COUNT, go to LOCKED and set LOCKED=1.
  - Below PERIOD-TOL: short error. good<=0, LOCKED<=0, state TRACK. The tick becomes the new reference.
- Missing error: in ARM/TRACK/LOCKED, a cycle with TICK=0 and cnt==PERIOD+TOL.
  - Go to ARM (cnt<=0, good<=0, LOCKED<=0).
  - A period above PERIOD+TOL is therefore always reported as missing, never as long.
- Error recording:
  - FAULT<=1.
  - ERR_CODE is written only if it is currently 00, so the first error is kept.
  - ERR_CNT increments and saturates at 255.
- CLEAR:
  - Zeroes FAULT, ERR_CODE and ERR_CNT.
  - If an error occurs in the same cycle, the error applies after the clear: FAULT=1, ERR_CODE=new code, ERR_CNT=1.
- Arithmetic:
  - cnt saturates at 2^W-1. It is unreachable in practice because the missing check fires first.
  - Range compares are unsigned at width W.

## Timing
- Reset values: LOCKED=0, FAULT=0, ERR_CODE=00, ERR_CNT=0, PERIOD_OUT=0, PERIOD_VALID=0. State is IDLE, cnt=0, good=0.
- All outputs are registered and reflect a TICK or missing condition one cycle later.
- LOCKED rises in the same cycle as the PERIOD_VALID of the LOCK_COUNT-th good period. That is the cycle after tick number LOCK_COUNT+1 following ARM.
- A missing error is flagged the cycle after cnt==PERIOD+TOL, which is PERIOD+TOL cycles after the last reference. In ARM, the count starts from ARM entry.
- EN falling: LOCKED=0 the next cycle. A TICK coincident with EN=0 produces no PERIOD_VALID.
- RESET_N asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
- Back-to-back ticks (p=1) are legal input and are classified as short when PERIOD-TOL > 1.

## Test plan
Parameters for all scenarios: PERIOD=10, TOL=2, LOCK_COUNT=3.
- Reset: assert RESET_N=0 mid-run -> all outputs 0 asynchronously. After release with EN=1 the block is in ARM and produces no PERIOD_VALID.
- Lock: ticks every 10 cycles -> PERIOD_VALID with PERIOD_OUT=10 after ticks 2, 3 and 4. LOCKED=1 with the 4th tick's PERIOD_VALID. FAULT=0.
- Short: while LOCKED, tick after 7 cycles -> PERIOD_OUT=7, LOCKED=0, FAULT=1, ERR_CODE=01, ERR_CNT=1. Three more 10-cycle periods -> LOCKED=1 again.
- Boundaries: periods 8 and 12 -> accepted, no fault. Period 7 -> short. No tick for 12 cycles -> missing: ERR_CODE=10 (only if it was 00), state ARM. The next tick produces no PERIOD_VALID.
- CLEAR plus error in the same cycle, with ERR_CNT=5 and ERR_CODE=01 beforehand, and the error being short -> FAULT=1, ERR_CODE=01, ERR_CNT=1.
- Saturation and enable: 300 short errors -> ERR_CNT=255. Drop EN while LOCKED -> LOCKED=0 the next cycle, FAULT and PERIOD_OUT held.
